// File: rtl/chip_test_pkg.sv
// Shared types and constants for the chip_74xx test front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chip_test_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        ACK       = 2'd3
    } seq_state_t;

    localparam int DEFAULT_NUM_CHIPS      = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    // Checker slot assigned to each supported part.
    localparam int SLOT_7400 = 0;
    localparam int SLOT_7402 = 1;
    localparam int SLOT_7404 = 2;
    localparam int SLOT_7408 = 3;
    localparam int SLOT_7410 = 4;
    localparam int SLOT_7420 = 5;
    localparam int SLOT_7432 = 6;
    localparam int SLOT_7486 = 7;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for an already-debounced level input (buttons).
// Latency: pulse is high in the cycle the input is first seen high.
// Backpressure: none; a rise that nobody consumes is simply lost.
// Ports: Clk, Reset (sync, active-high), in (level), pulse (one-cycle rise).
module rise_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic in,
    output logic pulse
);

    logic r_in_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_in_q <= 1'b0;
        end else begin
            r_in_q <= in;
        end
    end

    assign pulse = in & ~r_in_q;

endmodule

// File: rtl/chip_test_sequencer.sv
// Shared Run/acknowledge sequencer for the per-chip checker FSMs, with a bounded wait.
// Latency: Start rise at cycle 0 -> Run at cycle 1; flags and DISP_RSLT the cycle after Done.
// Backpressure: Start rises outside IDLE are dropped, never queued.
// Ports: Clk/Reset; Start, ChipSel in; Run_vec/DISP_RSLT one-hot to checkers;
//        Done_vec/RSLT_vec from checkers; Busy, Pass, Fail, Timeout, BadSel, SelLatched status.
module chip_test_sequencer
    import chip_test_pkg::*;
#(
    parameter int NUM_CHIPS      = DEFAULT_NUM_CHIPS,
    parameter int SEL_W          = 3,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [SEL_W-1:0]     ChipSel,
    output logic [NUM_CHIPS-1:0] Run_vec,
    input  logic [NUM_CHIPS-1:0] Done_vec,
    input  logic [NUM_CHIPS-1:0] RSLT_vec,
    output logic [NUM_CHIPS-1:0] DISP_RSLT,
    output logic                 Busy,
    output logic                 Pass,
    output logic                 Fail,
    output logic                 Timeout,
    output logic                 BadSel,
    output logic [SEL_W-1:0]     SelLatched
);

    localparam int                 CNT_W      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SEL_W:0]     NUM_CHIPS_W = (SEL_W + 1)'(NUM_CHIPS);

    seq_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_CHIPS-1:0]   r_run;
    logic [NUM_CHIPS-1:0]   r_disp;
    logic                   r_pass;
    logic                   r_fail;
    logic                   r_timeout;
    logic                   r_badsel;
    logic [SEL_W-1:0]       r_sel;

    logic                   w_start_edge;
    logic                   w_bad_sel;
    logic [NUM_CHIPS-1:0]   w_sel_oh;
    logic [NUM_CHIPS-1:0]   w_in_oh;
    logic                   w_done;
    logic                   w_rslt;

    rise_detect u_start_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .in    (Start),
        .pulse (w_start_edge)
    );

    // One-hot decodes built by compare so a SEL_W wider than log2(NUM_CHIPS)
    // never indexes past the vectors.
    always_comb begin
        w_sel_oh = '0;
        w_in_oh  = '0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            w_sel_oh[i] = (r_sel == SEL_W'(i));
            w_in_oh[i]  = (ChipSel == SEL_W'(i));
        end
    end

    assign w_bad_sel = ({1'b0, ChipSel} >= NUM_CHIPS_W);
    // Only the selected checker is watched; other Done/RSLT bits are masked off.
    assign w_done    = |(Done_vec & w_sel_oh);
    assign w_rslt    = |(RSLT_vec & w_sel_oh);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_run     <= '0;
            r_disp    <= '0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
            r_badsel  <= 1'b0;
            r_sel     <= '0;
        end else begin
            // Run and DISP_RSLT are single-cycle strobes.
            r_run  <= '0;
            r_disp <= '0;
            case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        r_sel     <= ChipSel;
                        r_pass    <= 1'b0;
                        r_fail    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_badsel  <= 1'b0;
                        if (w_bad_sel) begin
                            r_badsel <= 1'b1;
                            r_fail   <= 1'b1;
                        end else begin
                            // Run is registered here so it is high exactly during LAUNCH.
                            r_run   <= w_in_oh;
                            r_state <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_done) begin
                        r_pass  <= w_rslt;
                        r_fail  <= ~w_rslt;
                        r_disp  <= w_sel_oh;
                        r_state <= ACK;
                    end else if (r_cnt == CNT_LAST) begin
                        r_timeout <= 1'b1;
                        r_fail    <= 1'b1;
                        r_disp    <= w_sel_oh;
                        r_state   <= ACK;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Run_vec    = r_run;
    assign DISP_RSLT  = r_disp;
    assign Busy       = (r_state != IDLE);
    assign Pass       = r_pass;
    assign Fail       = r_fail;
    assign Timeout    = r_timeout;
    assign BadSel     = r_badsel;
    assign SelLatched = r_sel;

endmodule
